// File: rtl/write8to32.sv
// ============================================================================
// Module   : write8to32
// Purpose  : Packs an 8-bit byte stream little-endian into 32-bit words and
//            emits one (address, data) pair per word, starting at a captured
//            base address, for a captured number of words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module write8to32 (
  input  logic               _clock,
  input  logic               _reset_n,
  input  logic signed [31:0] base,
  input  logic signed [31:0] count,
  input  logic               _start,
  input  logic        [7:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               _ready,
  output logic               _valid,
  output logic               _done,
  output logic signed [31:0] _out0,
  output logic signed [31:0] _out1
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  state_t      r_state;
  logic [1:0]  r_byte_idx;
  logic [31:0] r_word_idx;
  // Only the three low lanes need storage; the top lane comes straight
  // from in_data on the edge that completes the word.
  logic [23:0] r_acc;
  logic [31:0] r_base;
  logic [31:0] r_count;

  logic        w_accept;
  logic        w_count_pos;
  logic        w_last_word;
  logic [31:0] w_addr;
  logic [31:0] w_word;

  // A fresh _start takes the cycle, so no byte is consumed alongside it.
  assign in_ready    = (r_state == ST_FILL) && !_start;
  assign w_accept    = in_valid && in_ready;
  assign w_count_pos = (count > 32'sd0);
  assign w_last_word = (r_word_idx == (r_count - 32'd1));
  // Address wraps modulo 2^32 by plain 32-bit addition.
  assign w_addr      = r_base + (r_word_idx << 2);
  assign w_word      = {in_data, r_acc};

  // Transfer control, byte packing and registered output stage.
  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      r_state    <= ST_IDLE;
      r_byte_idx <= 2'd0;
      r_word_idx <= 32'd0;
      r_acc      <= 24'd0;
      r_base     <= 32'd0;
      r_count    <= 32'd0;
      _valid     <= 1'b0;
      _done      <= 1'b0;
      _out0      <= 32'sd0;
      _out1      <= 32'sd0;
    end else if (_start) begin
      // New transfer wins over anything in flight; partial data is dropped.
      r_base     <= base;
      r_count    <= count;
      r_byte_idx <= 2'd0;
      r_word_idx <= 32'd0;
      r_acc      <= 24'd0;
      _valid     <= 1'b0;
      if (w_count_pos) begin
        r_state <= ST_FILL;
        _done   <= 1'b0;
      end else begin
        // Empty transfer: one-cycle completion marker, no data.
        r_state <= ST_IDLE;
        _done   <= 1'b1;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          _valid <= 1'b0;
          _done  <= 1'b0;
        end
        ST_FILL: begin
          if (w_accept) begin
            if (r_byte_idx == 2'd3) begin
              _out1      <= w_word;
              _out0      <= w_addr;
              _valid     <= 1'b1;
              _done      <= w_last_word;
              r_byte_idx <= 2'd0;
              r_acc      <= 24'd0;
              r_state    <= ST_EMIT;
            end else begin
              case (r_byte_idx)
                2'd0:    r_acc[7:0]   <= in_data;
                2'd1:    r_acc[15:8]  <= in_data;
                default: r_acc[23:16] <= in_data;
              endcase
              r_byte_idx <= r_byte_idx + 2'd1;
            end
          end
        end
        ST_EMIT: begin
          // Output held stable until the downstream handshake.
          if (_valid && _ready) begin
            _valid <= 1'b0;
            _done  <= 1'b0;
            if (w_last_word) begin
              r_state <= ST_IDLE;
            end else begin
              r_word_idx <= r_word_idx + 32'd1;
              r_state    <= ST_FILL;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          _valid  <= 1'b0;
          _done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/write8to32.md
WRITE8TO32 -- requirements
Module: write8to32

Interface
REQ-001 _clock  input  1  sole clock; all state changes on rising edge.
REQ-002 _reset_n  input  1  asynchronous, active-low reset; clears all state immediately, independent of _clock.
REQ-003 base  input  32 signed  start address of the first word; sampled only when _start high.
REQ-004 count  input  32 signed  number of 32-bit words to write; sampled only when _start high.
REQ-005 _start  input  1  capture base/count and begin a new transfer; overrides any transfer in progress.
REQ-006 in_data  input  8  byte from upstream stream.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  combinational; high iff state FILL and _start low.
REQ-009 _ready  input  1  downstream ready for an output word.
REQ-010 _valid  output reg  1  _out0/_out1 valid.
REQ-011 _done  output reg  1  transfer complete marker.
REQ-012 _out0  output reg  32 signed  write address.
REQ-013 _out1  output reg  32 signed  packed write data.

Function
REQ-014 States: IDLE, FILL, EMIT; internal byte_idx (2 bit), word_idx (32 bit), data accumulator (32 bit), captured _base/_count.
REQ-015 Byte accept: in_valid && in_ready at a rising edge; no other event consumes a byte.
REQ-016 Packing little-endian: byte_idx 0 -> bits [7:0], 1 -> [15:8], 2 -> [23:16], 3 -> [31:24].
REQ-017 IDLE: in_ready 0, _valid 0; leaves IDLE only on _start.
REQ-018 _start with count > 0: next cycle state FILL, byte_idx 0, word_idx 0, accumulator 0, _valid 0, _done 0.
REQ-019 _start with count <= 0: next cycle _done 1 and _valid 0 for exactly one cycle, then _done 0, state IDLE.
REQ-020 FILL: each accepted byte writes its lane and increments byte_idx; bytes not accepted while in_valid low.
REQ-021 Fourth byte accepted at edge N -> at edge N (registered, visible cycle N+1): _out1 = full word, _out0 = _base + (word_idx << 2), _valid 1, state EMIT, byte_idx 0.
REQ-022 Address arithmetic 32-bit, wraps modulo 2^32, no overflow flag.
REQ-023 _done 1 together with _valid when word_idx == _count - 1 (last word); 0 for all other words.
REQ-024 EMIT: in_ready 0; _out0/_out1/_valid/_done held stable until _valid && _ready at an edge.
REQ-025 EMIT handshake, not last word: _valid 0, word_idx + 1, state FILL next cycle.
REQ-026 EMIT handshake, last word: _valid 0, _done 0, state IDLE next cycle.
REQ-027 Minimum throughput: 5 cycles per word (4 byte accepts + 1 emit with _ready held high).
REQ-028 _start mid-transfer (FILL or EMIT): partial bytes and pending output discarded, _valid/_done forced 0, then REQ-018/019 apply; in_data offered in the _start cycle is not accepted.
REQ-029 _ready while _valid low has no effect; in_valid while in_ready low has no effect.

Reset
REQ-030 _reset_n low: state IDLE, _valid 0, _done 0, _out0 0, _out1 0, byte_idx 0, word_idx 0, accumulator 0, in_ready 0, asynchronously.
REQ-031 Reset asserted mid-transfer discards all partial data; no output produced after release until a new _start.
REQ-032 First _start honoured on the first rising edge after _reset_n deasserted.

Verification
REQ-033 base=0x1000, count=1, bytes 0x11,0x22,0x33,0x44 back-to-back, _ready=1 -> one output _out0=0x1000, _out1=0x44332211, _valid=1 and _done=1 in the same cycle, then IDLE.
REQ-034 base=0x2000, count=3, continuous bytes, _ready=1 -> addresses 0x2000, 0x2004, 0x2008; _done only on third; 15 cycles from first byte accept to last handshake.
REQ-035 count=2, _ready held low 4 cycles on word 0 -> _out0/_out1 stable, in_ready 0 throughout, no bytes lost; word 1 correct after release.
REQ-036 base=0xFFFFFFFC, count=2 -> addresses 0xFFFFFFFC then 0x00000000.
REQ-037 count=0 and count=-5 -> single-cycle _done=1 with _valid=0, no word, in_ready never high.
REQ-038 _start after 2 bytes of word 0, then new base=0x3000,count=1 and bytes 0xA0..0xA3 -> _out1=0xA3A2A1A0 at 0x3000; repeat with _reset_n pulsed low mid-FILL -> all outputs 0 immediately, no output until next _start.
